// File: rtl/piano_pkg.sv
// Shared definitions for the piano melody player: note bit positions,
// ROM entry layout, sequencer states and the built-in song.
package piano_pkg;

  // Bit positions in the 8-bit note-enable mask (same order as sw[7:0]).
  localparam int NOTE_C4 = 7;
  localparam int NOTE_D4 = 6;
  localparam int NOTE_E4 = 5;
  localparam int NOTE_F4 = 4;
  localparam int NOTE_G4 = 3;
  localparam int NOTE_A4 = 2;
  localparam int NOTE_B4 = 1;
  localparam int NOTE_C5 = 0;

  localparam int MAX_SONG_LEN = 16;

  // One ROM word: which tones sound, and for how many beat ticks.
  // A duration of zero marks the end of the song.
  typedef struct packed {
    logic [7:0] mask;
    logic [3:0] dur;
  } note_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_PLAY,
    ST_GAP
  } state_t;

  // Built-in tune: C-E-G-C' arpeggio up and back down, then terminator.
  // Element 15 is the leftmost word of the concatenation.
  localparam note_entry_t [MAX_SONG_LEN-1:0] DEFAULT_SONG = {
    {8{12'h000}},
    {8'h00, 4'd0},   // 7: end of song
    {8'h80, 4'd4},   // 6: C4
    {8'h20, 4'd2},   // 5: E4
    {8'h08, 4'd2},   // 4: G4
    {8'h01, 4'd4},   // 3: C5
    {8'h08, 4'd2},   // 2: G4
    {8'h20, 4'd2},   // 1: E4
    {8'h80, 4'd2}    // 0: C4
  };

endpackage

// File: rtl/melody_rom.sv
// Song ROM with a registered read port; the one-cycle read latency is
// what the sequencer's FETCH state waits out.
module melody_rom
  import piano_pkg::*;
#(
  parameter int                           SONG_LEN = 16,
  parameter note_entry_t [SONG_LEN-1:0]   SONG     = DEFAULT_SONG[SONG_LEN-1:0]
) (
  input  logic        clk,
  input  logic [3:0]  i_addr,
  output note_entry_t o_entry
);

  note_entry_t w_mem [MAX_SONG_LEN];
  note_entry_t r_entry;

  // Entries beyond the song length read as end-of-song markers.
  for (genvar gi = 0; gi < MAX_SONG_LEN; gi++) begin : g_mem
    if (gi < SONG_LEN) begin : g_used
      assign w_mem[gi] = SONG[gi];
    end else begin : g_pad
      assign w_mem[gi] = '0;
    end
  end

  // Registered read.
  always_ff @(posedge clk) begin
    r_entry <= w_mem[i_addr];
  end

  assign o_entry = r_entry;

endmodule

// File: rtl/melody_sequencer.sv
// Steps through the song ROM, driving the piano note-enable mask: each
// note plays for dur beat ticks, followed by one silent tick.
module melody_sequencer
  import piano_pkg::*;
#(
  parameter int                         TICK_DIV = 1562500,
  parameter int                         SONG_LEN = 16,
  parameter note_entry_t [SONG_LEN-1:0] SONG     = DEFAULT_SONG[SONG_LEN-1:0]
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       loop_en,
  output logic [7:0] note_mask,
  output logic       playing,
  output logic       done,
  output logic [3:0] step_idx
);

  localparam int             CW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0]  TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic [3:0]     STEP_LAST = 4'(SONG_LEN - 1);

  state_t        r_state, w_state_next;
  logic [3:0]    r_step, w_step_next;
  logic [3:0]    r_rem, w_rem_next;
  logic [CW-1:0] r_cnt, w_cnt_next;
  logic [7:0]    r_mask, w_mask_next;
  logic          r_done, w_done_next;
  logic          w_tick;
  logic          w_eos;
  note_entry_t   w_entry;

  // The ROM is addressed with the next step index so that the word for
  // the step being entered is ready during its FETCH cycle.
  melody_rom #(
    .SONG_LEN (SONG_LEN),
    .SONG     (SONG)
  ) u_rom (
    .clk     (clk),
    .i_addr  (w_step_next),
    .o_entry (w_entry)
  );

  assign w_tick = (r_cnt == TICK_LAST);

  // Next-state, next-output and counter logic.
  always_comb begin
    w_state_next = r_state;
    w_step_next  = r_step;
    w_rem_next   = r_rem;
    w_mask_next  = r_mask;
    w_cnt_next   = '0;
    w_done_next  = 1'b0;
    w_eos        = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_mask_next = '0;
        w_step_next = '0;
        if (start) w_state_next = ST_FETCH;
      end
      ST_FETCH: begin
        w_mask_next = '0;
        if (w_entry.dur != 4'd0) begin
          w_state_next = ST_PLAY;
          w_mask_next  = w_entry.mask;
          w_rem_next   = w_entry.dur;
        end else begin
          w_eos = 1'b1;
        end
      end
      ST_PLAY: begin
        if (w_tick) begin
          if (r_rem == 4'd1) begin
            w_state_next = ST_GAP;
            w_mask_next  = '0;
          end else begin
            w_rem_next = r_rem - 4'd1;
          end
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      ST_GAP: begin
        if (w_tick) begin
          if (r_step == STEP_LAST) begin
            w_eos = 1'b1;
          end else begin
            w_step_next  = r_step + 4'd1;
            w_state_next = ST_FETCH;
          end
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase

    // End of song: either loop back to the first entry or stop with done.
    if (w_eos) begin
      w_step_next = '0;
      w_mask_next = '0;
      if (loop_en) begin
        w_state_next = ST_FETCH;
      end else begin
        w_state_next = ST_IDLE;
        w_done_next  = 1'b1;
      end
    end

    // Stop overrides everything, including start and end-of-song.
    if (stop) begin
      w_state_next = ST_IDLE;
      w_step_next  = '0;
      w_mask_next  = '0;
      w_rem_next   = '0;
      w_cnt_next   = '0;
      w_done_next  = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_step  <= '0;
      r_rem   <= '0;
      r_cnt   <= '0;
      r_mask  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_step  <= w_step_next;
      r_rem   <= w_rem_next;
      r_cnt   <= w_cnt_next;
      r_mask  <= w_mask_next;
      r_done  <= w_done_next;
    end
  end

  assign note_mask = r_mask;
  assign playing   = (r_state != ST_IDLE);
  assign done      = r_done;
  assign step_idx  = r_step;

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer: a short terminated song on one
// instance, a full 16-entry unterminated song on a second instance.
module tb_melody_sequencer;
  import piano_pkg::*;

  localparam note_entry_t [15:0] SONG_A = {{14{12'h000}}, 12'h201, 12'h802};
  localparam note_entry_t [15:0] SONG_B = {
    12'hF01, 12'hE11, 12'hD21, 12'hC31, 12'hB41, 12'hA51, 12'h961, 12'h871,
    12'h781, 12'h691, 12'h5A1, 12'h4B1, 12'h3C1, 12'h2D1, 12'h1E1, 12'h0F1
  };

  logic       clk = 1'b0;
  logic       rst_a_n, start_a, stop_a, loop_a;
  logic       rst_b_n, start_b, stop_b, loop_b;
  logic [7:0] mask_a, mask_b;
  logic       play_a, play_b, done_a, done_b;
  logic [3:0] step_a, step_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  melody_sequencer #(.TICK_DIV(4), .SONG_LEN(16), .SONG(SONG_A)) dut_a (
    .clk(clk), .rst_n(rst_a_n), .start(start_a), .stop(stop_a), .loop_en(loop_a),
    .note_mask(mask_a), .playing(play_a), .done(done_a), .step_idx(step_a)
  );

  melody_sequencer #(.TICK_DIV(4), .SONG_LEN(16), .SONG(SONG_B)) dut_b (
    .clk(clk), .rst_n(rst_b_n), .start(start_b), .stop(stop_b), .loop_en(loop_b),
    .note_mask(mask_b), .playing(play_b), .done(done_b), .step_idx(step_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Advance past the next rising edge and settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Song A mask in cycle k after the start edge.
  function automatic logic [7:0] exp_a(input int k);
    if (k >= 2 && k <= 9)   return 8'h80;
    if (k >= 15 && k <= 18) return 8'h20;
    return 8'h00;
  endfunction

  // Song B entry i carries mask {i, ~i}.
  function automatic logic [7:0] exp_b(input int i);
    logic [3:0] n;
    n = 4'(i);
    return {n, ~n};
  endfunction

  initial begin
    rst_a_n = 1'b0; start_a = 1'b0; stop_a = 1'b0; loop_a = 1'b0;
    rst_b_n = 1'b0; start_b = 1'b0; stop_b = 1'b0; loop_b = 1'b0;
    step();
    chk("rst_mask_a", mask_a, 8'h00);
    chk("rst_play_a", play_a, 1'b0);
    chk("rst_done_a", done_a, 1'b0);
    chk("rst_step_a", step_a, 4'd0);
    chk("rst_mask_b", mask_b, 8'h00);
    chk("rst_play_b", play_b, 1'b0);
    step();
    rst_a_n = 1'b1; rst_b_n = 1'b1;
    step();
    chk("idle_play_a", play_a, 1'b0);
    $display("reset state checked");

    // Song A, no loop: full note/gap timeline.
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      chk($sformatf("A_mask_c%0d", k), mask_a, exp_a(k));
      if (k == 1)  chk("A_fetch_play_c1", play_a, 1'b1);
      if (k == 15) chk("A_step_c15", step_a, 4'd1);
      if (k == 23) chk("A_play_c23", play_a, 1'b1);
      if (k == 23) chk("A_done_c23", done_a, 1'b0);
      if (k < 24) step();
    end
    chk("A_done_c24", done_a, 1'b1);
    chk("A_play_c24", play_a, 1'b0);
    chk("A_step_c24", step_a, 4'd0);
    step();
    chk("A_done_c25", done_a, 1'b0);
    $display("song A single pass checked");

    // Song A with loop: refetch entry 0 at cycle 24, no done.
    loop_a = 1'b1;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      chk($sformatf("L_done_c%0d", k), done_a, 1'b0);
      if (k == 24) begin
        chk("L_play_c24", play_a, 1'b1);
        chk("L_mask_c24", mask_a, 8'h00);
        chk("L_step_c24", step_a, 4'd0);
      end
      if (k == 25) chk("L_mask_c25", mask_a, 8'h80);
      if (k < 25) step();
    end
    stop_a = 1'b1;
    step();
    stop_a = 1'b0;
    loop_a = 1'b0;
    chk("L_stop_play", play_a, 1'b0);
    chk("L_stop_mask", mask_a, 8'h00);
    $display("song A loop checked");

    // Stop mid-PLAY, then replay from entry 0 with full duration.
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    repeat (4) step();
    chk("S_mask_c5", mask_a, 8'h80);
    stop_a = 1'b1;
    step();
    stop_a = 1'b0;
    chk("S_mask_c6", mask_a, 8'h00);
    chk("S_play_c6", play_a, 1'b0);
    chk("S_step_c6", step_a, 4'd0);
    chk("S_done_c6", done_a, 1'b0);
    step();
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      chk($sformatf("R_mask_c%0d", k), mask_a, exp_a(k));
      if (k < 10) step();
    end
    stop_a = 1'b1;
    step();
    stop_a = 1'b0;
    $display("stop and replay checked");

    // start and stop together in IDLE: stays idle.
    start_a = 1'b1;
    stop_a  = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk($sformatf("SS_play_%0d", k), play_a, 1'b0);
      chk($sformatf("SS_mask_%0d", k), mask_a, 8'h00);
    end
    start_a = 1'b0;
    stop_a  = 1'b0;
    step();
    $display("start+stop in idle checked");

    // start held high across done: immediate restart.
    start_a = 1'b1;
    step();
    for (int k = 1; k <= 26; k++) begin
      if (k == 24) chk("H_done_c24", done_a, 1'b1);
      if (k == 25) begin
        chk("H_play_c25", play_a, 1'b1);
        chk("H_mask_c25", mask_a, 8'h00);
      end
      if (k == 26) chk("H_mask_c26", mask_a, 8'h80);
      if (k < 26) step();
    end
    start_a = 1'b0;
    stop_a = 1'b1;
    step();
    stop_a = 1'b0;
    $display("held start restart checked");

    // Asynchronous reset mid-PLAY.
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    repeat (3) step();
    chk("AR_mask_c4", mask_a, 8'h80);
    #2;
    rst_a_n = 1'b0;
    #1;
    chk("AR_mask_async", mask_a, 8'h00);
    chk("AR_play_async", play_a, 1'b0);
    chk("AR_step_async", step_a, 4'd0);
    chk("AR_done_async", done_a, 1'b0);
    step();
    rst_a_n = 1'b1;
    repeat (3) step();
    chk("AR_idle_play", play_a, 1'b0);
    chk("AR_idle_mask", mask_a, 8'h00);
    $display("async reset checked");

    // Song B, 16 entries of dur 1, no loop: done after entry 15 gap.
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    for (int k = 1; k <= 145; k++) begin
      if (k == 74) begin
        chk("B_step_c74", step_b, 4'd8);
        chk("B_mask_c74", mask_b, exp_b(8));
      end
      if (k == 137) begin
        chk("B_step_c137", step_b, 4'd15);
        chk("B_mask_c137", mask_b, exp_b(15));
      end
      if (k == 144) begin
        chk("B_play_c144", play_b, 1'b1);
        chk("B_done_c144", done_b, 1'b0);
      end
      if (k == 145) begin
        chk("B_done_c145", done_b, 1'b1);
        chk("B_play_c145", play_b, 1'b0);
        chk("B_step_c145", step_b, 4'd0);
      end
      if (k < 145) step();
    end
    step();
    $display("song B single pass checked");

    // Song B with loop: wraps 15 -> 0.
    loop_b = 1'b1;
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    for (int k = 1; k <= 146; k++) begin
      if (k == 145) begin
        chk("BL_play_c145", play_b, 1'b1);
        chk("BL_done_c145", done_b, 1'b0);
        chk("BL_step_c145", step_b, 4'd0);
      end
      if (k == 146) chk("BL_mask_c146", mask_b, exp_b(0));
      if (k < 146) step();
    end
    stop_b = 1'b1;
    step();
    stop_b = 1'b0;
    chk("BL_stop_play", play_b, 1'b0);
    $display("song B loop checked");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/melody_sequencer.md
# melody_sequencer

Plays a fixed song from an on-chip note ROM by driving the 8-bit note-enable mask that gates the eight tone generators of the piano, in place of the manual switch bank. Each note lasts a programmable number of beat ticks and is followed by one tick of silence. Start, stop and loop controls come from the board buttons. The block sits directly upstream of the piano's per-note AND gates.

## Interface
- TICK_DIV, 1562500: clk cycles per beat tick (1/16 s at 25 MHz); bench uses 4.
- SONG_LEN, 16: ROM depth in entries (power of two, max 16).
- clk  in  1  system clock, 25 MHz.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- start  in  1  synchronous level, sampled each edge; starts playback from entry 0 when idle.
- stop  in  1  synchronous; aborts playback.
- loop_en  in  1  at end of song, restart at entry 0 instead of stopping.
- note_mask  out  8  registered note enables; bit 7 = C4 … bit 0 = C5, same order as sw[7:0].
- playing  out  1  high in FETCH, PLAY, GAP.
- done  out  1  one-cycle pulse on natural (non-stop) end of song.
- step_idx  out  4  index of current ROM entry.

## Operation
- ROM entry = {mask[7:0], dur[3:0]}; dur = 0 is the end-of-song marker.
- States: IDLE, FETCH, PLAY, GAP.
- IDLE: note_mask=0, step_idx=0. start=1 → FETCH.
- FETCH (exactly 1 cycle): ROM address = step_idx; note_mask=0. On exit: dur≠0 → PLAY, load mask into note_mask, remaining=dur; dur=0 → end-of-song.
- PLAY: note_mask held; on each tick remaining−−; tick with remaining=1 → GAP.
- GAP: note_mask=0 for one tick; on the tick: step_idx=SONG_LEN−1 → end-of-song, else step_idx++ and → FETCH.
- End-of-song: loop_en=1 → step_idx=0, FETCH, no done pulse. loop_en=0 → IDLE with done=1 for that cycle.
- stop=1 in any state → IDLE next cycle: note_mask=0, step_idx=0, done=0. stop has priority over start and over the end-of-song transition.
- start while not IDLE: ignored. start held high in IDLE after done: immediately restarts.
- Tick counter: 0..TICK_DIV−1, cleared on every entry to PLAY and GAP. Tick = counter at TICK_DIV−1. Ticks are defined only in PLAY and GAP.
- remaining is 4 bits and never wraps, since dur ≥ 1 in PLAY.

## Timing
- Reset values: state IDLE, note_mask=0, playing=0, done=0, step_idx=0, counters 0.
- start sampled at edge N → FETCH during cycle N+1 → note_mask valid from N+2.
- PLAY lasts exactly dur·TICK_DIV cycles; GAP exactly TICK_DIV cycles.
- Note period = 1 + (dur+1)·TICK_DIV cycles.
- done asserts in the first IDLE cycle, which follows the terminating FETCH or last GAP.
- stop sampled at edge N → note_mask=0 and playing=0 from cycle N+1.
- Reset mid-note: all outputs return to reset values asynchronously.

## Structure
- Shared package piano_pkg:
  - note bit constants (NOTE_C4=7 … NOTE_C5=0)
  - note_entry_t {mask, dur}
  - state enum
  - default song constant array.
- Sub-module melody_rom: synchronous read, address in, note_entry_t out, contents from piano_pkg.
  - Its 1-cycle latency is the FETCH state.
- Tick counter stays inline.

## Test plan
- TICK_DIV=4. ROM: e0={8'h80,2}, e1={8'h20,1}, e2={8'h00,0}. Start pulse at edge 0 → note_mask:
  - 0 in cycle 1
  - 8'h80 cycles 2–9
  - 0 cycles 10–14
  - 8'h20 cycles 15–18
  - 0 cycles 19–23

  Then done=1 in cycle 24, playing=0, step_idx=0.
- Same ROM, loop_en=1 → after the e1 gap, FETCH of e0 at cycle 24; 8'h80 again from cycle 25; done never asserts.
- stop pulsed in cycle 5 (mid-PLAY) → note_mask=0, playing=0, step_idx=0 at cycle 6; a later start replays from e0 with full dur.
- start and stop both high in IDLE → remains IDLE; note_mask stays 0.
- ROM with 16 entries, all dur=1, no terminator → step_idx wraps 15→0 only when loop_en=1. With loop_en=0, done pulses after the entry 15 gap.
- Reset asserted mid-PLAY → note_mask=0 asynchronously (before the next clk edge); after release, IDLE until start.
